reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 49 ++++
 rtl/reg_writeback.sv | 125 ++++++++++++
 tb/tb_reg_writeback.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared CPU constants and the MEM write entry layout used by the writeback stage.
// Pure declarations, no logic.
// No flow control.
package reg_writeback_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    typedef struct packed {
        logic                  bank;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// Generic circular FIFO with occupancy count; the head is visible on rdata while non-empty.
// Latency: an entry is visible at the head the cycle after its push.
// Backpressure: push is ignored when full and pop is ignored when empty; there is no pass-through.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr] <= wdata;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Merges the ALU and buffered MEM write streams onto the two register-file banks.
// Latency: one cycle from ALU accept or FIFO dequeue to write_en.
// Backpressure: ALU never stalls; MEM stalls via mem_ready when the FIFO is full.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    input  logic                         alu_bank,
    input  logic [REG_ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]            alu_data,
    input  logic                         mem_valid,
    input  logic                         mem_bank,
    input  logic [REG_ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         mem_ready,
    output logic                         write_en_A,
    output logic                         write_en_B,
    output logic [REG_ADDR_W-1:0]        write_addr_A,
    output logic [REG_ADDR_W-1:0]        write_addr_B,
    output logic [DATA_W-1:0]            write_data_A,
    output logic [DATA_W-1:0]            write_data_B,
    output logic [NUM_REGS-1:0]          busy_A,
    output logic [NUM_REGS-1:0]          busy_B,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t                           mem_entry, head;
    logic [ENTRY_W-1:0]                  head_bits;
    logic                                fifo_full, fifo_empty, push, pop;
    logic [NUM_REGS-1:0]                 inc_a, inc_b, dec_a, dec_b;
    logic [NUM_REGS-1:0][CNT_W-1:0]      pend_a, pend_b;

    assign mem_entry = '{bank: mem_bank, addr: mem_addr, data: mem_data};
    assign mem_ready = !fifo_full;
    assign push      = mem_valid && mem_ready;
    assign head      = wb_entry_t'(head_bits);
    // The ALU owns its bank this cycle; the head may only use the other one.
    assign pop       = !fifo_empty && (!alu_valid || head.bank != alu_bank);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (mem_entry),
        .pop   (pop),
        .rdata (head_bits),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_en_A   <= 1'b0;
            write_en_B   <= 1'b0;
            write_addr_A <= '0;
            write_addr_B <= '0;
            write_data_A <= '0;
            write_data_B <= '0;
        end else begin
            write_en_A <= (alu_valid && alu_bank == BANK_A) || (pop && head.bank == BANK_A);
            write_en_B <= (alu_valid && alu_bank == BANK_B) || (pop && head.bank == BANK_B);
            if (alu_valid && alu_bank == BANK_A) begin
                write_addr_A <= alu_addr;
                write_data_A <= alu_data;
            end else if (pop && head.bank == BANK_A) begin
                write_addr_A <= head.addr;
                write_data_A <= head.data;
            end
            if (alu_valid && alu_bank == BANK_B) begin
                write_addr_B <= alu_addr;
                write_data_B <= alu_data;
            end else if (pop && head.bank == BANK_B) begin
                write_addr_B <= head.addr;
                write_data_B <= head.data;
            end
        end
    end

    // Per-register count of queued writes; duplicates keep busy set until the last one drains.
    always_comb begin
        inc_a = '0;
        inc_b = '0;
        dec_a = '0;
        dec_b = '0;
        if (push && mem_bank == BANK_A)  inc_a[mem_addr]  = 1'b1;
        if (push && mem_bank == BANK_B)  inc_b[mem_addr]  = 1'b1;
        if (pop && head.bank == BANK_A)  dec_a[head.addr] = 1'b1;
        if (pop && head.bank == BANK_B)  dec_b[head.addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_a <= '0;
            pend_b <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_a[r] <= pend_a[r] + CNT_W'(inc_a[r]) - CNT_W'(dec_a[r]);
                pend_b[r] <= pend_b[r] + CNT_W'(inc_b[r]) - CNT_W'(dec_b[r]);
            end
        end
    end

    always_comb begin
        busy_A = '0;
        busy_B = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_A[r] = |pend_a[r];
            busy_B[r] = |pend_b[r];
        end
    end

    // Upstream must stall an ALU write whose target still has a queued MEM write.
    alu_target_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        alu_valid |-> !((alu_bank == BANK_A) ? busy_A[alu_addr] : busy_B[alu_addr]));

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus randomized traffic
// compared against a queue-based model of the writeback rules.
module tb_reg_writeback;
    import reg_writeback_pkg::*;

    localparam int DEPTH = 4;

    logic        clk, rst_n;
    logic        alu_valid, alu_bank, mem_valid, mem_bank, mem_ready;
    logic [4:0]  alu_addr, mem_addr, write_addr_A, write_addr_B;
    logic [31:0] alu_data, mem_data, write_data_A, write_data_B, busy_A, busy_B;
    logic        write_en_A, write_en_B;
    logic [2:0]  fifo_count;

    int checks = 0;
    int fails  = 0;

    reg_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_bank(alu_bank), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_bank(mem_bank), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready),
        .write_en_A(write_en_A), .write_en_B(write_en_B),
        .write_addr_A(write_addr_A), .write_addr_B(write_addr_B),
        .write_data_A(write_data_A), .write_data_B(write_data_B),
        .busy_A(busy_A), .busy_B(busy_B), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending MEM writes in arrival order plus the last issued write per bank.
    wb_entry_t   mq[$];
    logic        m_en_a, m_en_b;
    logic [4:0]  m_addr_a, m_addr_b;
    logic [31:0] m_data_a, m_data_b;

    logic [143:0] dut_obs;
    assign dut_obs = {write_en_A, write_en_B, write_addr_A, write_addr_B, write_data_A,
                      write_data_B, busy_A, busy_B, mem_ready, fifo_count};

    function automatic logic [143:0] exp_vec();
        logic [31:0] ba, bb;
        ba = '0;
        bb = '0;
        foreach (mq[i]) begin
            if (mq[i].bank == BANK_A) ba[mq[i].addr] = 1'b1;
            else                      bb[mq[i].addr] = 1'b1;
        end
        return {m_en_a, m_en_b, m_addr_a, m_addr_b, m_data_a, m_data_b, ba, bb,
                (mq.size() != DEPTH), 3'(mq.size())};
    endfunction

    function automatic logic model_busy(input logic bank, input logic [4:0] addr);
        foreach (mq[i]) if (mq[i].bank == bank && mq[i].addr == addr) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        wb_entry_t h;
        logic      ready, pop_ok;
        if (!rst_n) begin
            mq.delete();
            {m_en_a, m_en_b, m_addr_a, m_addr_b, m_data_a, m_data_b} = '0;
        end else begin
            ready  = (mq.size() != DEPTH);
            pop_ok = (mq.size() != 0) && (!alu_valid || mq[0].bank != alu_bank);
            m_en_a = 1'b0;
            m_en_b = 1'b0;
            if (alu_valid) begin
                if (alu_bank == BANK_A) begin m_en_a = 1'b1; m_addr_a = alu_addr; m_data_a = alu_data; end
                else                    begin m_en_b = 1'b1; m_addr_b = alu_addr; m_data_b = alu_data; end
            end
            if (pop_ok) begin
                h = mq.pop_front();
                if (h.bank == BANK_A) begin m_en_a = 1'b1; m_addr_a = h.addr; m_data_a = h.data; end
                else                  begin m_en_b = 1'b1; m_addr_b = h.addr; m_data_b = h.data; end
            end
            if (mem_valid && ready) mq.push_back('{bank: mem_bank, addr: mem_addr, data: mem_data});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_alu(input logic v, input logic b, input logic [4:0] a, input logic [31:0] d);
        alu_valid = v; alu_bank = b; alu_addr = a; alu_data = d;
    endtask

    task automatic set_mem(input logic v, input logic b, input logic [4:0] a, input logic [31:0] d);
        mem_valid = v; mem_bank = b; mem_addr = a; mem_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_alu(1'b1, BANK_A, 5'd1, 32'h1);
        set_mem(1'b1, BANK_B, 5'd2, 32'h2);
        tick();
        tick();
        checks++;
        if (dut_obs !== exp_vec()) begin
            fails++; $display("FAIL reset_state: got %h want %h", dut_obs, exp_vec());
        end
        checks++;
        if ({write_en_A, write_en_B, fifo_count, busy_A, busy_B, mem_ready} !== {2'b00, 3'd0, 64'd0, 1'b1}) begin
            fails++; $display("FAIL reset_const: en=%b%b cnt=%0d busyA=%h busyB=%h rdy=%b",
                              write_en_A, write_en_B, fifo_count, busy_A, busy_B, mem_ready);
        end
        set_alu(1'b0, BANK_A, 5'd0, 32'h0);
        set_mem(1'b0, BANK_A, 5'd0, 32'h0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_basic();
        set_alu(1'b1, BANK_A, 5'd5, 32'hDEADBEEF);
        tick();
        set_alu(1'b0, BANK_A, 5'd0, 32'h0);
        checks++;
        if ({write_en_A, write_addr_A, write_data_A, write_en_B} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b0}) begin
            fails++; $display("FAIL alu_basic: enA=%b addrA=%0d dataA=%h enB=%b want 1/5/deadbeef/0",
                              write_en_A, write_addr_A, write_data_A, write_en_B);
        end
        tick();
        checks++;
        if (write_en_A !== 1'b0) begin
            fails++; $display("FAIL alu_basic_drop: enA=%b want 0", write_en_A);
        end
    endtask

    task automatic test_alu_mem_parallel();
        set_alu(1'b1, BANK_A, 5'd3, 32'h33333333);
        set_mem(1'b1, BANK_B, 5'd7, 32'h77770007);
        tick();
        set_alu(1'b0, BANK_A, 5'd0, 32'h0);
        set_mem(1'b0, BANK_A, 5'd0, 32'h0);
        checks++;
        if ({write_en_A, write_addr_A, fifo_count, busy_B[7]} !== {1'b1, 5'd3, 3'd1, 1'b1}) begin
            fails++; $display("FAIL parallel_alu: enA=%b addrA=%0d cnt=%0d busyB7=%b want 1/3/1/1",
                              write_en_A, write_addr_A, fifo_count, busy_B[7]);
        end
        tick();
        checks++;
        if ({write_en_B, write_addr_B, write_data_B, fifo_count, busy_B[7]} !==
            {1'b1, 5'd7, 32'h77770007, 3'd0, 1'b0}) begin
            fails++; $display("FAIL parallel_mem: enB=%b addrB=%0d dataB=%h cnt=%0d busyB7=%b",
                              write_en_B, write_addr_B, write_data_B, fifo_count, busy_B[7]);
        end
    endtask

    task automatic test_fill_priority();
        for (int i = 0; i < 4; i++) begin
            set_alu(1'b1, BANK_A, 5'(20 + i), 32'(i));
            set_mem(1'b1, BANK_A, 5'(1 + i), 32'hA0000000 + 32'(i));
            tick();
        end
        checks++;
        if ({mem_ready, fifo_count} !== {1'b0, 3'd4}) begin
            fails++; $display("FAIL fill_full: rdy=%b cnt=%0d want 0/4", mem_ready, fifo_count);
        end
        set_alu(1'b1, BANK_A, 5'd24, 32'h4);
        set_mem(1'b1, BANK_A, 5'd5, 32'hA0000004);
        tick();
        set_alu(1'b0, BANK_A, 5'd0, 32'h0);
        set_mem(1'b0, BANK_A, 5'd0, 32'h0);
        checks++;
        if ({mem_ready, fifo_count, busy_A[5]} !== {1'b0, 3'd4, 1'b0}) begin
            fails++; $display("FAIL fill_reject: rdy=%b cnt=%0d busyA5=%b want 0/4/0",
                              mem_ready, fifo_count, busy_A[5]);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({write_en_A, write_addr_A, write_data_A} !== {1'b1, 5'(1 + i), 32'hA0000000 + 32'(i)}) begin
                fails++; $display("FAIL fill_drain[%0d]: enA=%b addrA=%0d dataA=%h", i,
                                  write_en_A, write_addr_A, write_data_A);
            end
        end
        tick();
        checks++;
        if ({write_en_A, fifo_count, mem_ready} !== {1'b0, 3'd0, 1'b1}) begin
            fails++; $display("FAIL fill_empty: enA=%b cnt=%0d rdy=%b", write_en_A, fifo_count, mem_ready);
        end
    endtask

    task automatic test_busy_dup();
        set_mem(1'b1, BANK_B, 5'd9, 32'h900D0001);
        tick();
        checks++;
        if (busy_B[9] !== 1'b1) begin
            fails++; $display("FAIL dup_set: busyB9=%b want 1", busy_B[9]);
        end
        set_mem(1'b1, BANK_B, 5'd9, 32'h900D0002);
        tick();
        set_mem(1'b0, BANK_A, 5'd0, 32'h0);
        checks++;
        if ({write_en_B, write_addr_B, write_data_B, busy_B[9], fifo_count} !==
            {1'b1, 5'd9, 32'h900D0001, 1'b1, 3'd1}) begin
            fails++; $display("FAIL dup_first: enB=%b addrB=%0d dataB=%h busyB9=%b cnt=%0d",
                              write_en_B, write_addr_B, write_data_B, busy_B[9], fifo_count);
        end
        tick();
        checks++;
        if ({write_en_B, write_data_B, busy_B[9], fifo_count} !== {1'b1, 32'h900D0002, 1'b0, 3'd0}) begin
            fails++; $display("FAIL dup_second: enB=%b dataB=%h busyB9=%b cnt=%0d",
                              write_en_B, write_data_B, busy_B[9], fifo_count);
        end
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 3; i++) begin
            set_alu(1'b1, BANK_A, 5'(20 + i), 32'h0);
            set_mem(1'b1, BANK_A, 5'(10 + i), 32'hC0DE0000 + 32'(i));
            tick();
        end
        checks++;
        if (fifo_count !== 3'd3) begin
            fails++; $display("FAIL flush_fill: cnt=%0d want 3", fifo_count);
        end
        rst_n = 1'b0;
        set_alu(1'b1, BANK_B, 5'd1, 32'h1);
        set_mem(1'b1, BANK_A, 5'd11, 32'h2);
        tick();
        rst_n = 1'b1;
        set_alu(1'b0, BANK_A, 5'd0, 32'h0);
        set_mem(1'b0, BANK_A, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({write_en_A, write_en_B, fifo_count, busy_A, busy_B, mem_ready} !== {2'b00, 3'd0, 64'd0, 1'b1}) begin
                fails++; $display("FAIL flush[%0d]: en=%b%b cnt=%0d busyA=%h busyB=%h rdy=%b", i,
                                  write_en_A, write_en_B, fifo_count, busy_A, busy_B, mem_ready);
            end
            tick();
        end
    endtask

    task automatic test_hold();
        set_alu(1'b1, BANK_A, 5'd2, 32'h1234);
        tick();
        set_alu(1'b0, BANK_A, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({write_en_A, write_addr_A, write_data_A} !== {1'b0, 5'd2, 32'h1234}) begin
                fails++; $display("FAIL hold[%0d]: enA=%b addrA=%0d dataA=%h want 0/2/1234", i,
                                  write_en_A, write_addr_A, write_data_A);
            end
        end
    endtask

    task automatic test_random();
        logic       b;
        logic [4:0] a;
        for (int c = 0; c < 500; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            b = 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 31));
            set_alu(($urandom_range(0, 1) == 1) && !model_busy(b, a), b, a, $urandom);
            set_mem($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            tick();
            checks++;
            if (dut_obs !== exp_vec()) begin
                fails++; $display("FAIL random[%0d]: got %h want %h", c, dut_obs, exp_vec());
            end
        end
        rst_n = 1'b1;
        set_alu(1'b0, BANK_A, 5'd0, 32'h0);
        set_mem(1'b0, BANK_A, 5'd0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_alu(1'b0, BANK_A, 5'd0, 32'h0);
        set_mem(1'b0, BANK_A, 5'd0, 32'h0);
        test_reset();
        test_alu_basic();
        test_alu_mem_parallel();
        test_fill_priority();
        test_busy_dup();
        test_reset_flush();
        test_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
